mac_array_seq_ctrl: RTL and testbench

Sequencer for the 2D MAC array built from mac_row instances. On a start pulse it streams kernel weights in (inst 01), waits for weights to settle, streams activation vectors (inst 10), then counts valid psums leaving the last column until the job completes. It drives the activation/weight SRAM read port and the array's west-edge instruction bus, and sits between the top-level host control and the array.

---
 rtl/mac_array_seq_ctrl_if.sv | 27 ++
 rtl/mac_array_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mac_array_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mac_array_seq_ctrl_if.sv
// Control/bus bundle between host, SRAM read port, MAC array and the sequencer.
// master = host/array side, slave = mac_array_seq_ctrl.
interface mac_array_seq_ctrl_if #(
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
);
    logic               start;
    logic [len_bw-1:0]  num_vec;
    logic [col-1:0]     array_valid;
    logic               mem_rd_en;
    logic [addr_bw-1:0] mem_addr;
    logic [1:0]         inst_w;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, num_vec, array_valid,
        input  mem_rd_en, mem_addr, inst_w, busy, done, err
    );

    modport slave (
        input  start, num_vec, array_valid,
        output mem_rd_en, mem_addr, inst_w, busy, done, err
    );
endinterface

// File: rtl/mac_array_seq_ctrl.sv
// Job sequencer for the mac_row array: kernel load, flush, execute, drain, done.
// Optional drain watchdog enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_array_seq_ctrl #(
    parameter int col       = 8,
    parameter int row       = 8,
    parameter int flush_cyc = 16,
    parameter int len_bw    = 8,
    parameter int addr_bw   = 11
) (
    input  logic                clk,
    input  logic                reset,
    mac_array_seq_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KLOAD  = 3'd1;
    localparam logic [2:0] S_KFLUSH = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // One shared phase counter covers the kernel, flush and execute lengths.
    localparam int KC_W = $clog2(col + 1);
    localparam int FC_W = $clog2(((flush_cyc > row + col) ? flush_cyc : row + col) + 1);
    localparam int M_W  = (KC_W > FC_W) ? KC_W : FC_W;
    localparam int PH_W = (M_W > len_bw) ? M_W : len_bw;

    logic [2:0]         r_state;
    logic [PH_W-1:0]    r_phase;
    logic [len_bw-1:0]  r_nv_q;
    logic [len_bw-1:0]  r_out_cnt;
    logic [1:0]         r_rd_kind;
    logic               r_mem_rd_en;
    logic [addr_bw-1:0] r_mem_addr;
    logic [1:0]         r_inst_w;
    logic               r_busy;
    logic               r_done;

    logic               w_valid_last;
    logic               w_counting;
    logic [PH_W-1:0]    w_phase_inc;
    logic [len_bw-1:0]  w_out_cnt_nxt;
    logic               w_unused_valid;

`ifdef MAC_SEQ_TIMEOUT_EN
    logic [9:0]         r_wd;
    logic               r_err;
    logic [9:0]         w_wd_inc;
`endif

    // Next-value helpers: phase increment and saturating psum count.
    always_comb begin
        w_valid_last   = bus.array_valid[col-1];
        w_unused_valid = ^bus.array_valid;
        w_phase_inc    = r_phase + PH_W'(1);
        w_counting     = (r_state == S_EXEC) || (r_state == S_DRAIN);
        if (w_counting && w_valid_last && (r_out_cnt != r_nv_q)) begin
            w_out_cnt_nxt = r_out_cnt + len_bw'(1);
        end else begin
            w_out_cnt_nxt = r_out_cnt;
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        w_wd_inc = r_wd + 10'd1;
`endif
    end

    // Sequencer state, SRAM read port, instruction pipe and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= {PH_W{1'b0}};
            r_nv_q      <= {len_bw{1'b0}};
            r_out_cnt   <= {len_bw{1'b0}};
            r_rd_kind   <= 2'b00;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= {addr_bw{1'b0}};
            r_inst_w    <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            r_wd        <= 10'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            // SRAM data lands one cycle after the read, so the instruction trails it.
            r_inst_w <= r_rd_kind;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_nv_q      <= bus.num_vec;
                        r_out_cnt   <= {len_bw{1'b0}};
                        r_phase     <= {PH_W{1'b0}};
                        r_rd_kind   <= 2'b01;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= {addr_bw{1'b0}};
                        r_busy      <= 1'b1;
                        r_state     <= S_KLOAD;
`ifdef MAC_SEQ_TIMEOUT_EN
                        r_wd        <= 10'd0;
                        r_err       <= 1'b0;
`endif
                    end
                end
                S_KLOAD: begin
                    if (w_phase_inc == PH_W'(col)) begin
                        r_phase     <= {PH_W{1'b0}};
                        r_rd_kind   <= 2'b00;
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_KFLUSH;
                    end else begin
                        r_phase    <= w_phase_inc;
                        r_mem_addr <= r_mem_addr + addr_bw'(1);
                    end
                end
                S_KFLUSH: begin
                    if (w_phase_inc == PH_W'(flush_cyc)) begin
                        r_phase <= {PH_W{1'b0}};
                        if (r_nv_q != {len_bw{1'b0}}) begin
                            r_rd_kind   <= 2'b10;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= addr_bw'(col);
                            r_state     <= S_EXEC;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_phase <= w_phase_inc;
                    end
                end
                S_EXEC: begin
                    r_out_cnt <= w_out_cnt_nxt;
                    if (w_phase_inc == PH_W'(r_nv_q)) begin
                        r_phase     <= {PH_W{1'b0}};
                        r_rd_kind   <= 2'b00;
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_phase    <= w_phase_inc;
                        r_mem_addr <= r_mem_addr + addr_bw'(1);
                    end
                end
                S_DRAIN: begin
                    r_out_cnt <= w_out_cnt_nxt;
                    if (w_out_cnt_nxt == r_nv_q) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
`ifdef MAC_SEQ_TIMEOUT_EN
                    else if (w_valid_last) begin
                        r_wd <= 10'd0;
                    end else if (w_wd_inc == 10'd1023) begin
                        r_wd    <= w_wd_inc;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_kind   <= 2'b00;
                    r_mem_rd_en <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.inst_w    = r_inst_w;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
`ifdef MAC_SEQ_TIMEOUT_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Bench for mac_array_seq_ctrl: directed job table plus randomized jobs checked
// cycle by cycle against a timeline model of each job.
module tb_mac_array_seq_ctrl;
    localparam int COL     = 8;
    localparam int ROW     = 8;
    localparam int FLUSH   = 16;
    localparam int LEN_BW  = 8;
    localparam int ADDR_BW = 11;
    localparam int E0      = 1 + COL + FLUSH;  // first execute cycle, job start = cycle 0

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_array_seq_ctrl_if #(.col(COL), .len_bw(LEN_BW), .addr_bw(ADDR_BW)) bus ();

    mac_array_seq_ctrl #(
        .col(COL), .row(ROW), .flush_cyc(FLUSH), .len_bw(LEN_BW), .addr_bw(ADDR_BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int nv;
        int v1_first;
        int v1_len;
        int v2_first;
        int v2_len;
        int ign;
        int abort_at;
        int exp_done;
    } vec_t;

    vec_t tbl [11];
    logic vpat [0:2047];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   last_addr = 0;
    int   last_err  = 0;

    function automatic logic [16:0] pack_out();
        return {bus.mem_rd_en, bus.mem_addr, bus.inst_w, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input int t, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d actual{rd,addr,inst,busy,done,err}=%0b,%0d,%b,%0b,%0b,%0b required=%0b,%0d,%b,%0b,%0b,%0b",
                     name, t, act[16], act[15:5], act[4:3], act[2], act[1], act[0],
                     exp[16], exp[15:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Read kind issued in cycle t of a job: 01 kernel, 10 execute.
    function automatic logic [1:0] rd_kind(input int t, input int nv);
        if (t >= 1 && t <= COL) return 2'b01;
        if (t >= E0 && t < E0 + nv) return 2'b10;
        return 2'b00;
    endfunction

    // Done cycle of a job from the counting rules; -1 when it never finishes.
    task automatic model_done(input int nv, output int d, output int e);
        int cnt;
        int quiet;
        cnt = 0; quiet = 0; d = -1; e = 0;
        if (nv == 0) begin
            d = E0;
        end else begin
            for (int t = E0; t < 2048 && d < 0; t++) begin
                if (vpat[t] && cnt < nv) cnt++;
                if (t >= E0 + nv) begin
                    if (cnt == nv) d = t + 1;
                    else if (vpat[t]) quiet = 0;
                    else begin
                        quiet++;
`ifdef MAC_SEQ_TIMEOUT_EN
                        if (quiet == 1023) begin
                            d = t + 1;
                            e = 1;
                        end
`endif
                    end
                end
            end
        end
    endtask

    task automatic run_job(input int nv, input int ign, input int abort_at, output int seen);
        int d, e, tmax, ea;
        logic [16:0] exp;
        model_done(nv, d, e);
        tmax = (d >= 0) ? d : abort_at;
        seen = -1;
        for (int t = 0; t <= tmax; t++) begin
            @(negedge clk);
            if (t == 0) ea = last_addr;
            else if (t <= COL) ea = t - 1;
            else if (nv == 0 || t < E0) ea = COL - 1;
            else if (t < E0 + nv) ea = COL + t - E0;
            else ea = COL + nv - 1;
            exp = {rd_kind(t, nv) != 2'b00, ADDR_BW'(ea),
                   (t == 0) ? 2'b00 : rd_kind(t - 1, nv),
                   (t >= 1) && (d < 0 || t < d),
                   t == d,
                   (t == 0) ? (last_err != 0) : ((d >= 0 && t >= d) ? (e != 0) : 1'b0)};
            check("job_cycle", t, pack_out(), exp);
            if (bus.done === 1'b1 && seen < 0) seen = t;
            if (t == abort_at) begin
                reset = 1'b1;
                #1;
                check("async_reset", t, pack_out(), 17'd0);
                bus.start = 1'b0;
                bus.array_valid = '0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                last_addr = 0;
                last_err = 0;
                return;
            end
            bus.start       = (t == 0) || (t == ign);
            bus.num_vec     = (t == 0) ? LEN_BW'(nv) : 8'd9;
            bus.array_valid = {vpat[t], 7'($urandom)};
        end
        last_addr = (nv == 0) ? COL - 1 : COL + nv - 1;
        last_err  = e;
    endtask

    initial begin
        int seen;
        int p;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_vec = '0;
        bus.array_valid = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 0, pack_out(), 17'd0);
        reset = 1'b0;

        //          nv v1f v1l v2f v2l  ign abort done
        tbl[0]  = '{4, 29, 4,  0,  0,  -1,  -1,  33};
        tbl[1]  = '{4, 29, 4,  0,  0,  26,  -1,  33};
        tbl[2]  = '{0, 0,  0,  0,  0,  -1,  -1,  25};
        tbl[3]  = '{4, 27, 10, 0,  0,  -1,  -1,  31};
        tbl[4]  = '{2, 10, 5,  40, 2,  -1,  -1,  42};
        tbl[5]  = '{3, 25, 3,  0,  0,  -1,  -1,  29};
        tbl[6]  = '{1, 25, 1,  0,  0,  -1,  -1,  27};
        tbl[7]  = '{4, 29, 4,  0,  0,  -1,  27,  -1};
        tbl[8]  = '{4, 29, 4,  0,  0,  -1,  -1,  33};
`ifdef MAC_SEQ_TIMEOUT_EN
        tbl[9]  = '{4, 29, 2,  0,  0,  -1, 1100, 1054};
`else
        tbl[9]  = '{4, 29, 2,  0,  0,  -1, 1100, -1};
`endif
        tbl[10] = '{5, 30, 5,  0,  0,  35,  -1,  35};

        for (int i = 0; i < 11; i++) begin
            for (int t = 0; t < 2048; t++) begin
                vpat[t] = (t >= tbl[i].v1_first && t < tbl[i].v1_first + tbl[i].v1_len) ||
                          (t >= tbl[i].v2_first && t < tbl[i].v2_first + tbl[i].v2_len);
            end
            run_job(tbl[i].nv, tbl[i].ign, tbl[i].abort_at, seen);
            check_int($sformatf("done_cycle_row%0d", i), seen, tbl[i].exp_done);
        end

        for (int j = 0; j < 25; j++) begin
            p = $urandom_range(10, 90);
            for (int t = 0; t < 2048; t++) begin
                vpat[t] = (t < 200) ? ($urandom_range(0, 99) < p) : 1'b1;
            end
            run_job($urandom_range(0, 20), $urandom_range(1, 60), -1, seen);
        end

        @(negedge clk);
        bus.start = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
